// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory stage: pipeline bus widths,
//   load_type encodings and packed views of the exe->mem and mem->wb buses.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 76;
  localparam int MS_TO_WS_BUS_WD = 70;

  // Encodings 5..7 are not named; they behave like LW.
  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_type_e;

  typedef struct packed {
    logic [2:0]  load_type;
    logic [1:0]  addr_low;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
//   Purely combinational load-data extraction: picks the addressed byte or
//   halfword out of a little-endian 32-bit word and sign/zero extends it.
// Ports:
//   load_type [2:0]  in   load kind (LW/LB/LBU/LH/LHU, others act as LW)
//   addr_low  [1:0]  in   low address bits selecting byte/halfword lane
//   rdata     [31:0] in   raw word from data memory
//   load_data [31:0] out  aligned and extended result
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: byte lanes follow addr_low, halfword lane follows addr_low[1].
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_low)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (load_type)
      LOAD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: load_data = {24'd0, byte_sel};
      LOAD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: load_data = {16'd0, half_sel};
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory stage of the five-stage pipeline. Holds one instruction from exe,
//   forms the load result from synchronous-read SRAM data and hands it to
//   writeback. SRAM data is only valid in the first cycle an instruction sits
//   here, so a stall in that cycle captures it into rdata_buf.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   ws_allowin           writeback can accept
//   ms_allowin           this stage can accept from exe
//   es_to_ms_valid/bus   instruction offered by exe
//   ms_to_ws_valid/bus   instruction offered to writeback
//   data_sram_rdata      SRAM read data for last cycle's exe address
//   ms_fw_*              forwarding path back to decode
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_fw_valid,
  output logic                       ms_fw_we,
  output logic [4:0]                 ms_fw_dest,
  output logic [31:0]                ms_fw_data
);

  logic        ms_valid;
  logic        ms_first;
  logic        rdata_buf_valid;
  logic [31:0] rdata_buf;
  es_to_ms_t   ms_reg;
  ms_to_ws_t   ws_out;
  logic        ms_ready_go;
  logic        capture;
  logic        buffer_rdata;
  logic [31:0] eff_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign capture        = es_to_ms_valid && ms_allowin;
  // ms_first implies ms_valid, and a stall in that cycle loses the SRAM data
  // next cycle unless it is kept here.
  assign buffer_rdata   = ms_first && !ws_allowin;

  // Control state: cleared on reset so any in-flight instruction and
  // buffered data are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid        <= 1'b0;
      ms_first        <= 1'b0;
      rdata_buf_valid <= 1'b0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      ms_first <= capture;
      if (capture) begin
        rdata_buf_valid <= 1'b0;
      end else if (buffer_rdata) begin
        rdata_buf_valid <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; they are qualified by the control bits.
  always_ff @(posedge clk) begin
    if (capture) begin
      ms_reg <= es_to_ms_t'(es_to_ms_bus);
    end
    if (buffer_rdata) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign eff_rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata;

  mem_load_align u_load_align (
    .load_type (ms_reg.load_type),
    .addr_low  (ms_reg.addr_low),
    .rdata     (eff_rdata),
    .load_data (load_data)
  );

  assign final_result = ms_reg.res_from_mem ? load_data : ms_reg.alu_result;

  always_comb begin
    ws_out              = '0;
    ws_out.gr_we        = ms_reg.gr_we;
    ws_out.dest         = ms_reg.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = ms_reg.pc;
  end

  assign ms_to_ws_bus = ws_out;
  assign ms_fw_valid  = ms_valid;
  assign ms_fw_we     = ms_reg.gr_we;
  assign ms_fw_dest   = ms_reg.dest;
  assign ms_fw_data   = final_result;

endmodule
